cdc_test_sequencer: RTL and testbench

CDC_TEST_SEQUENCER -- requirements
Module: cdc_test_sequencer

---
 rtl/cdc_test_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cdc_test_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_test_sequencer.sv
// Drives a toggle-strobed data pattern into a CDC checker, then reads back its counters
// to decide pass/fail for the run.
module cdc_test_sequencer #(
    parameter int CLR_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int MIN_GAP      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_edges_cfg,
    input  logic [7:0]  gap_cfg,
    input  logic        inject_err,
    output logic [7:0]  tx_data,
    output logic        tx_edge,
    output logic        chk_reset,
    input  logic [15:0] chk_num_edges,
    input  logic [15:0] chk_num_miscompares,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] edges_sent
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SEND_DATA,
        SEND_EDGE,
        GAP,
        DRAIN,
        CHECK
    } state_t;

    localparam logic [7:0] CLR_LOAD   = 8'(CLR_CYCLES - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] MIN_GAP_L  = (MIN_GAP > 255) ? 8'hFF : 8'(MIN_GAP);

    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] num_lat;
    logic [7:0]  gap_lat;
    logic        inj_lat;
    logic [7:0]  pattern;
    logic [7:0]  next_pattern;
    logic [7:0]  gap_eff;
    logic [7:0]  gap_load;

    // A zero effective gap (only possible with MIN_GAP=0) still needs one GAP cycle.
    always_comb begin
        gap_eff  = (gap_lat > MIN_GAP_L) ? gap_lat : MIN_GAP_L;
        gap_load = (gap_eff == 8'd0) ? 8'd0 : gap_eff - 8'd1;
        case (pattern)
            8'h81:   next_pattern = 8'h42;
            8'h42:   next_pattern = 8'h24;
            8'h24:   next_pattern = 8'h18;
            default: next_pattern = 8'h81;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            num_lat    <= 16'd0;
            gap_lat    <= 8'd0;
            inj_lat    <= 1'b0;
            pattern    <= 8'h00;
            tx_data    <= 8'h00;
            tx_edge    <= 1'b0;
            chk_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            edges_sent <= 16'd0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
                chk_reset <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            num_lat    <= num_edges_cfg;
                            gap_lat    <= gap_cfg;
                            inj_lat    <= inject_err;
                            edges_sent <= 16'd0;
                            pass       <= 1'b0;
                            pattern    <= 8'h00;
                            tx_data    <= 8'h00;
                            chk_reset  <= 1'b1;
                            cnt        <= CLR_LOAD;
                            busy       <= 1'b1;
                            state      <= CLR;
                        end
                    end
                    CLR: begin
                        if (cnt == 8'd0) begin
                            chk_reset <= 1'b0;
                            if (num_lat == 16'd0) begin
                                cnt   <= DRAIN_LOAD;
                                state <= DRAIN;
                            end else begin
                                state <= SEND_DATA;
                            end
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    // Corruption affects only the driven value, so later edges stay in sequence.
                    SEND_DATA: begin
                        pattern <= next_pattern;
                        tx_data <= (inj_lat && edges_sent == 16'd2) ? (next_pattern ^ 8'h01)
                                                                    : next_pattern;
                        state   <= SEND_EDGE;
                    end
                    SEND_EDGE: begin
                        tx_edge    <= ~tx_edge;
                        edges_sent <= edges_sent + 16'd1;
                        cnt        <= gap_load;
                        state      <= GAP;
                    end
                    GAP: begin
                        if (cnt == 8'd0) begin
                            if (edges_sent == num_lat) begin
                                cnt   <= DRAIN_LOAD;
                                state <= DRAIN;
                            end else begin
                                state <= SEND_DATA;
                            end
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    DRAIN: begin
                        if (cnt == 8'd0) begin
                            state <= CHECK;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    CHECK: begin
                        pass  <= (chk_num_edges == num_lat) && (chk_num_miscompares == 16'd0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdc_test_sequencer.sv
// Bench for cdc_test_sequencer: loopback checker model plus a timeline model of each run,
// exercised with directed scenarios and randomized runs.
module tb_cdc_test_sequencer;

    localparam int CLR_C   = 4;
    localparam int DRAIN_C = 8;
    localparam int MIN_G   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] num_edges_cfg;
    logic [7:0]  gap_cfg;
    logic        inject_err;
    logic [7:0]  tx_data;
    logic        tx_edge;
    logic        chk_reset;
    logic [15:0] chk_num_edges;
    logic [15:0] chk_num_miscompares;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] edges_sent;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cdc_test_sequencer #(
        .CLR_CYCLES  (CLR_C),
        .DRAIN_CYCLES(DRAIN_C),
        .MIN_GAP     (MIN_G)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .num_edges_cfg      (num_edges_cfg),
        .gap_cfg            (gap_cfg),
        .inject_err         (inject_err),
        .tx_data            (tx_data),
        .tx_edge            (tx_edge),
        .chk_reset          (chk_reset),
        .chk_num_edges      (chk_num_edges),
        .chk_num_miscompares(chk_num_miscompares),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .edges_sent         (edges_sent)
    );

    // Loopback checker: counts toggles and compares captured data to the expected pattern.
    logic [7:0]  pat [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
    logic [15:0] m_edges = 16'd0;
    logic [15:0] m_mis   = 16'd0;
    logic        m_prev  = 1'b0;
    int          m_idx   = 0;
    int          bias    = 0;

    always @(posedge clk) begin
        if (chk_reset) begin
            m_edges <= 16'd0;
            m_mis   <= 16'd0;
            m_idx   <= 0;
            m_prev  <= tx_edge;
        end else if (tx_edge != m_prev) begin
            m_prev  <= tx_edge;
            m_edges <= m_edges + 16'd1;
            if (tx_data != pat[m_idx % 4]) m_mis <= m_mis + 16'd1;
            m_idx   <= m_idx + 1;
        end
    end

    assign chk_num_edges       = m_edges + 16'(bias);
    assign chk_num_miscompares = m_mis;

    function automatic logic [7:0] expData(input int k, input bit inj);
        logic [7:0] v;
        case (k % 4)
            0:       v = 8'h81;
            1:       v = 8'h42;
            2:       v = 8'h24;
            default: v = 8'h18;
        endcase
        if (inj && k == 2) v = v ^ 8'h01;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkResetValues(input string pre);
        checkOutput({pre, "_busy"}, busy, 0);
        checkOutput({pre, "_done"}, done, 0);
        checkOutput({pre, "_pass"}, pass, 0);
        checkOutput({pre, "_tx_edge"}, tx_edge, 0);
        checkOutput({pre, "_tx_data"}, tx_data, 0);
        checkOutput({pre, "_chk_reset"}, chk_reset, 0);
        checkOutput({pre, "_edges_sent"}, edges_sent, 0);
    endtask

    // Launches a run; returns at the negedge of the first cycle after start was accepted.
    task automatic applyStimulus(input int n, input int g, input bit inj, input int b,
                                 input bit hold, input bit with_abort, output logic e0);
        @(negedge clk);
        e0            = tx_edge;
        bias          = b;
        num_edges_cfg = 16'(n);
        gap_cfg       = 8'(g);
        inject_err    = inj;
        start         = 1'b1;
        abort         = with_abort;
        @(negedge clk);
        abort         = 1'b0;
        if (!hold) start = 1'b0;
        num_edges_cfg = 16'($urandom);
        gap_cfg       = 8'($urandom);
        inject_err    = 1'($urandom);
    endtask

    task automatic runCheck(input int n, input int g, input bit inj, input int b,
                            input bit hold, input bit with_abort);
        int         per      = 2 + ((g > MIN_G) ? g : MIN_G);
        int         exp_done = CLR_C + n * per + DRAIN_C + 2;
        int         limit    = exp_done + 10;
        bit         exp_pass = (b == 0) && !(inj && n >= 3);
        int         done_cyc = -1;
        int         cr_cnt   = 0;
        int         busy_cnt = 0;
        int         tog[$];
        logic [7:0] dat[$];
        logic [7:0] pre[$];
        logic       e0;
        logic       prev;
        logic [7:0] last_data;

        applyStimulus(n, g, inj, b, hold, with_abort, e0);
        prev      = e0;
        last_data = tx_data;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (chk_reset) cr_cnt++;
            if (busy) busy_cnt++;
            if (tx_edge !== prev) begin
                tog.push_back(cyc);
                dat.push_back(tx_data);
                pre.push_back(last_data);
                prev = tx_edge;
            end
            last_data = tx_data;
            if (done) begin
                done_cyc = cyc;
                start    = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;

        checkOutput("done_cycle", done_cyc, exp_done);
        checkOutput("chk_reset_len", cr_cnt, CLR_C);
        checkOutput("busy_len", busy_cnt, exp_done - 1);
        checkOutput("edge_count", tog.size(), n);
        for (int k = 0; k < tog.size() && k < n; k++) begin
            checkOutput("edge_time", tog[k], CLR_C + 3 + k * per);
            checkOutput("edge_data", dat[k], expData(k, inj));
            checkOutput("data_setup", pre[k], expData(k, inj));
        end
        if (done_cyc > 0) begin
            checkOutput("pass", pass, exp_pass);
            checkOutput("edges_sent", edges_sent, n);
            checkOutput("busy_at_done", busy, 0);
            @(negedge clk);
            checkOutput("done_width", done, 0);
            checkOutput("pass_hold", pass, exp_pass);
            checkOutput("idle_after", busy, 0);
        end
    endtask

    task automatic abortAt(input int n, input int g, input int acyc,
                           input logic [7:0] exp_d, input int exp_sent);
        logic e0;
        applyStimulus(n, g, 1'b0, 0, 1'b0, 1'b0, e0);
        repeat (acyc - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_done", done, 1);
        checkOutput("abort_pass", pass, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_tx_data", tx_data, exp_d);
        checkOutput("abort_tx_edge", tx_edge, e0 ^ 1'(exp_sent % 2));
        checkOutput("abort_edges_sent", edges_sent, exp_sent);
        checkOutput("abort_chk_reset", chk_reset, 0);
        @(negedge clk);
        checkOutput("abort_done_width", done, 0);
    endtask

    initial begin
        int   dones;
        logic e0;

        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        inject_err    = 1'b0;
        num_edges_cfg = 16'd0;
        gap_cfg       = 8'd0;
        repeat (3) @(negedge clk);
        checkResetValues("por");
        reset = 1'b0;

        runCheck(4, 6, 1'b0, 0, 1'b0, 1'b0);
        runCheck(3, 0, 1'b0, 0, 1'b0, 1'b0);
        runCheck(5, 6, 1'b1, 0, 1'b0, 1'b0);
        runCheck(0, 6, 1'b0, 0, 1'b0, 1'b0);
        runCheck(0, 3, 1'b0, 1, 1'b0, 1'b0);

        // Abort in the GAP after edge 2, then in the CHECK cycle of a one-edge run.
        abortAt(4, 6, CLR_C + 3 + 8, 8'h42, 2);
        runCheck(4, 6, 1'b0, 0, 1'b0, 1'b0);
        abortAt(1, 0, CLR_C + 6 + DRAIN_C + 1, 8'h81, 1);

        applyStimulus(3, 5, 1'b0, 0, 1'b0, 1'b0, e0);
        repeat (CLR_C + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetValues("midrun");
        dones = 0;
        repeat (20) begin
            if (done) dones++;
            @(negedge clk);
        end
        checkOutput("no_done_after_reset", dones, 0);
        checkOutput("idle_after_reset", busy, 0);

        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_over_start", busy, 0);

        runCheck(2, 5, 1'b0, 0, 1'b1, 1'b0);
        runCheck(2, 4, 1'b0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            runCheck($urandom_range(0, 6), $urandom_range(0, 9), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
